// File: rtl/sort_pkg.sv
// sort_pkg: shared state type and width helpers for the sorter family
package sort_pkg;
  typedef enum logic {IDLE, SORT} sort_state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/cmp_swap.sv
// cmp_swap: one compare-exchange cell; a/ta in, ya/tya out on the left, b/tb -> yb/tyb on the right, swapped flags an exchange
module cmp_swap #(
  parameter int W = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [IW-1:0] ta,
  input  logic [IW-1:0] tb,
  input  logic          desc,
  output logic [W-1:0]  ya,
  output logic [W-1:0]  yb,
  output logic [IW-1:0] tya,
  output logic [IW-1:0] tyb,
  output logic          swapped
);
  assign swapped = desc ? (a < b) : (a > b);
  assign ya = swapped ? b : a;
  assign yb = swapped ? a : b;
  assign tya = swapped ? tb : ta;
  assign tyb = swapped ? ta : tb;
endmodule

// File: rtl/odd_even_sort.sv
// odd_even_sort: odd-even transposition sorter; clk/rst, start+descending+data_in in, data_out/idx_out/phases/busy/done out
module odd_even_sort
  import sort_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  localparam int IW = idx_w(N),
  localparam int PW = cnt_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  descending,
  input  logic [N-1:0][W-1:0]   data_in,
  output logic [N-1:0][W-1:0]   data_out,
  output logic [N-1:0][IW-1:0]  idx_out,
  output logic                  busy,
  output logic                  done,
  output logic [PW-1:0]         phases
);
  if (N < 2) begin : g_n_check
    $error("odd_even_sort needs N >= 2");
  end
  sort_state_t state;
  logic mode, swap_even, phase_swap, last;
  logic [PW-1:0] p;
  logic [N-1:0][W-1:0] key, key_nx;
  logic [N-1:0][IW-1:0] tag, tag_nx;
  logic [N-2:0][W-1:0] ya, yb;
  logic [N-2:0][IW-1:0] tya, tyb;
  logic [N-2:0] sw;
  for (genvar i = 0; i < N - 1; i++) begin : g_cs
    cmp_swap #(.W(W), .IW(IW)) u_cs (
      .a(key[i]), .b(key[i+1]), .ta(tag[i]), .tb(tag[i+1]), .desc(mode),
      .ya(ya[i]), .yb(yb[i]), .tya(tya[i]), .tyb(tyb[i]), .swapped(sw[i])
    );
  end
  // Cell i is active when its left position has the parity of the current phase.
  always_comb begin
    key_nx = key;
    tag_nx = tag;
    phase_swap = 1'b0;
    for (int k = 0; k < N - 1; k++)
      if (k[0] == p[0]) begin
        key_nx[k] = ya[k];
        key_nx[k+1] = yb[k];
        tag_nx[k] = tya[k];
        tag_nx[k+1] = tyb[k];
        phase_swap = phase_swap | sw[k];
      end
  end
  // On an odd phase phase_swap is the odd-phase flag; paired with swap_even it covers a full phase pair.
  assign last = (p == PW'(N - 1)) || (p[0] && !phase_swap && !swap_even);
  assign busy = (state == SORT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode <= 1'b0;
      swap_even <= 1'b0;
      p <= '0;
      key <= '0;
      tag <= '0;
      data_out <= '0;
      idx_out <= '0;
      phases <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          key <= data_in;
          for (int k = 0; k < N; k++) tag[k] <= IW'(k);
          mode <= descending;
          p <= '0;
          swap_even <= 1'b0;
          state <= SORT;
        end
      end else begin
        key <= key_nx;
        tag <= tag_nx;
        if (!p[0]) swap_even <= phase_swap;
        if (last) begin
          data_out <= key_nx;
          idx_out <= tag_nx;
          phases <= p + 1'b1;
          done <= 1'b1;
          state <= IDLE;
        end else begin
          p <= p + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/odd_even_sort.md
# odd_even_sort

- Parametrised odd-even transposition sorter, N keys of W bits.
- Sorts ascending or descending, selected per run.
- Outputs the original index of every sorted key, so callers can permute associated payloads.
- Stops early once a full even+odd phase pair makes no swap.
- Sits in the same sorting datapath as the existing single-comparator sorter and replaces it where throughput or payload tracking matters.
- Compares all disjoint adjacent pairs in one cycle, so worst-case latency is N cycles instead of ~N²/2.

## Interface

- N, default 8: number of keys; N ≥ 2, checked by an elaboration assertion.
- W, default 8: key width in bits.
- IW, derived as $clog2(N): index tag width.
- PW, derived as $clog2(N+1): phase-count width.

- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  run request; accepted only in IDLE.
- descending  in  1  sort order; 1 = largest first; sampled with start.
- data_in  in  [N-1:0][W-1:0]  keys; sampled only on the accepting edge.
- data_out  out  [N-1:0][W-1:0]  sorted keys; held until the next completion.
- idx_out  out  [N-1:0][IW-1:0]  idx_out[k] is the input position of data_out[k].
- busy  out  1  high while in SORT.
- done  out  1  one-cycle completion pulse.
- phases  out  PW  number of phases executed by the last run; held.

## Operation

- Reset values: state IDLE; busy 0; done 0; data_out all 0; idx_out all 0; phases 0. Internal arrays and counters are also cleared.
- Reset mid-run abandons the run; there is no partial output.
- IDLE:
  - On start=1, latch data_in into the working key array.
  - Load working tags with tag[k]=k.
  - Latch descending into a mode register; clear the phase counter p and the swap flags.
  - Go to SORT.
- SORT, one phase per cycle:
  - Even phase (p even): compare-exchange pairs (0,1),(2,3),…
  - Odd phase (p odd): compare-exchange pairs (1,2),(3,4),…
  - When N is odd or even, the unpaired end element is untouched.
- Exchange rule: the tag moves with its key.
  - Ascending: swap iff left > right.
  - Descending: swap iff left < right.
  - Equal keys never swap, so the sort is stable: among equal keys, lower original index comes first.
- Swap flags:
  - swap_even records whether any swap occurred in the most recent even phase.
  - swap_odd is computed combinationally for the current odd phase.
- Termination is evaluated at the end of each phase, on the post-phase values.
  - (a) p+1 == N, or
  - (b) p is odd and neither the current phase nor the preceding even phase swapped.
- On termination, at the same edge as the last phase:
  - data_out/idx_out ← post-phase arrays.
  - phases ← p+1.
  - done ← 1; state ← IDLE.
- Otherwise p increments.
- start while busy is ignored and is not queued.
- The mode register is used for the whole run; changing descending mid-run has no effect.

## Timing

- Start sampled at edge e0; phases execute at edges e1…eP; done is high during the cycle after eP, for exactly one cycle.
- Latency from start edge to done: P cycles, with 2 ≤ P ≤ N.
  - Already-sorted input: P = 2.
  - Worst case: P = N.
- busy rises the cycle after e0 and falls in the same cycle done rises.
- data_out, idx_out and phases change only at the completion edge; they are stable whenever done = 1 and afterwards.
- start high in the done cycle is accepted, since state is IDLE; back-to-back runs cost no idle cycle. done still pulses for the finished run.
- rst has priority over start and over completion on the same edge.

## Structure

- Package sort_pkg:
  - state enum sort_state_t {IDLE, SORT}.
  - A localparam function for derived widths (clog2 helpers), shared with other sorters.
- Sub-module cmp_swap, purely combinational, parametrised by W and IW.
  - Inputs: keys a/b, tags ta/tb, desc.
  - Outputs: ordered keys/tags and a swapped bit.
  - Instantiated with a generate loop, once per adjacent position.
  - Top level muxes even/odd phase results per position.

## Test plan

- Reset, then N=8, W=8, ascending, input {5,3,8,1,9,2,7,4} → data_out {1,2,3,4,5,7,8,9}; idx_out {3,5,1,7,0,6,2,4}; done one cycle; phases ≤ 8.
- Already sorted {0,1,…,7}, ascending → phases = 2; done exactly 2 cycles after the start edge; idx_out = {0…7}.
- Reverse input {7,…,0}, descending=1 → data_out {7,…,0}, phases = 2. Same input ascending → phases = 8, data_out {0…7}.
- Duplicates {4,2,4,2,4,2,4,2}, ascending → data_out {2,2,2,2,4,4,4,4}; idx_out {1,3,5,7,0,2,4,6} (stability).
- start pulsed while busy → ignored, outputs from the first run only. start in the done cycle → second run accepted, second done P cycles later. rst asserted mid-run → all outputs 0 next cycle, no done.
- N=5, W=12: random 1000 runs in both modes against a reference model. Each run checks: sorted order, idx_out is a permutation, data_out[k] == input[idx_out[k]], and phases ≤ 5.
